// File: rtl/i2so_sched.sv
// I2S output scheduler: sck divider, source arbitration and a one-entry
// holding buffer answering the serializer's per-frame ready-to-receive.
module i2so_sched #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic             cfg_src_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             src0_valid,
  input  logic [15:0]      src0_lft,
  input  logic [15:0]      src0_rgt,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [15:0]      src1_lft,
  input  logic [15:0]      src1_rgt,
  output logic             src1_ready,
  output logic             sck,
  output logic             sck_transition,
  output logic             ser_rts,
  input  logic             ser_rtr,
  output logic [15:0]      ser_lft,
  output logic [15:0]      ser_rgt,
  output logic             active_src,
  output logic             busy,
  output logic [CNT_W-1:0] underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lim;
  logic [DIV_W-1:0] div_eff;
  logic             buf_valid;
  logic [15:0]      buf_lft;
  logic [15:0]      buf_rgt;
  logic             sel_valid;
  logic             fill;
  logic             wrap;
  logic             to_idle;

  assign div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign sel_valid = active_src ? src1_valid : src0_valid;
  // fill and drain never share a cycle
  assign fill      = (state_q == PRIME || state_q == RUN) &&
                     !buf_valid && !ser_rtr && sel_valid;
  assign src0_ready = fill && !active_src;
  assign src1_ready = fill && active_src;

  assign ser_lft = buf_valid ? buf_lft : 16'h0000;
  assign ser_rgt = buf_valid ? buf_rgt : 16'h0000;
  assign busy    = (state_q != IDLE);
  assign wrap    = (div_cnt == div_lim);
  assign to_idle = (state_q != IDLE) && (state_d == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cfg_enable) state_d = PRIME;
      PRIME: begin
        if (!cfg_enable)            state_d = IDLE;
        else if (fill || buf_valid) state_d = RUN;
      end
      RUN:   if (!cfg_enable) state_d = DRAIN;
      DRAIN: if (ser_rtr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt        <= '0;
      div_lim        <= DIV_W'(1);
      sck            <= 1'b0;
      sck_transition <= 1'b0;
    end else if (state_q == IDLE || to_idle) begin
      div_cnt        <= '0;
      div_lim        <= div_eff;
      sck            <= 1'b0;
      sck_transition <= 1'b0;
    end else begin
      sck_transition <= wrap && !sck;
      if (wrap) begin
        div_cnt <= '0;
        div_lim <= div_eff;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_rts      <= 1'b0;
      buf_valid    <= 1'b0;
      buf_lft      <= '0;
      buf_rgt      <= '0;
      active_src   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (to_idle)
        ser_rts <= 1'b0;
      else if (state_q == PRIME && state_d == RUN)
        ser_rts <= 1'b1;

      if (to_idle) begin
        buf_valid <= 1'b0;
      end else if (fill) begin
        buf_valid <= 1'b1;
        buf_lft   <= active_src ? src1_lft : src0_lft;
        buf_rgt   <= active_src ? src1_rgt : src0_rgt;
      end else if (ser_rtr) begin
        buf_valid <= 1'b0;
      end

      if (ser_rtr && !buf_valid && state_q != IDLE &&
          underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + CNT_W'(1);

      // switch only at a frame boundary, after the buffered sample leaves
      if (state_q == IDLE || ser_rtr)
        active_src <= cfg_src_sel;
    end
  end

endmodule

// File: tb/tb_i2so_sched.sv
// Self-checking bench for i2so_sched: directed scenarios plus a randomized
// run scored against a sample-queue reference model.
module tb_i2so_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_src_sel = 1'b0;
  logic [7:0]  cfg_div = 8'd3;
  logic        src0_valid = 1'b0;
  logic [15:0] src0_lft = '0;
  logic [15:0] src0_rgt = '0;
  logic        src0_ready;
  logic        src1_valid = 1'b0;
  logic [15:0] src1_lft = '0;
  logic [15:0] src1_rgt = '0;
  logic        src1_ready;
  logic        sck;
  logic        sck_transition;
  logic        ser_rts;
  logic        ser_rtr = 1'b0;
  logic [15:0] ser_lft;
  logic [15:0] ser_rgt;
  logic        active_src;
  logic        busy;
  logic [7:0]  underrun_cnt;

  int checks = 0;
  int failures = 0;

  i2so_sched #(.DIV_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_src_sel(cfg_src_sel),
    .cfg_div(cfg_div),
    .src0_valid(src0_valid), .src0_lft(src0_lft),
    .src0_rgt(src0_rgt), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_lft(src1_lft),
    .src1_rgt(src1_rgt), .src1_ready(src1_ready),
    .sck(sck), .sck_transition(sck_transition),
    .ser_rts(ser_rts), .ser_rtr(ser_rtr),
    .ser_lft(ser_lft), .ser_rgt(ser_rgt),
    .active_src(active_src), .busy(busy),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_src_sel = 1'b0;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    ser_rtr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // enable and wait (bounded) until the first sample is held and rts is up
  task automatic bring_up(input logic sel, input logic [15:0] l,
                          input logic [15:0] r);
    int n;
    cfg_src_sel = sel;
    if (sel) begin
      src1_lft = l; src1_rgt = r; src1_valid = 1'b1;
    end else begin
      src0_lft = l; src0_rgt = r; src0_valid = 1'b1;
    end
    cfg_enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ser_rts && n < 20);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    if (!ser_rts) begin
      checks++; failures++;
      $display("FAIL bring_up_timeout: ser_rts=%b required 1", ser_rts);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sck, sck_transition, ser_rts, src0_ready, src1_ready,
         active_src, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b required 0000000",
               {sck, sck_transition, ser_rts, src0_ready, src1_ready,
                active_src, busy});
    end
    checks++;
    if (underrun_cnt !== 8'd0 || {ser_lft, ser_rgt} !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: cnt=%0d lft=%h rgt=%h required 0",
               underrun_cnt, ser_lft, ser_rgt);
    end
    src0_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || src0_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b ready=%b required 0 0",
               busy, src0_ready);
    end
    src0_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    cfg_div = 8'd3;
    cfg_src_sel = 1'b0;
    src0_lft = 16'h1234;
    src0_rgt = 16'hABCD;
    src0_valid = 1'b1;
    cfg_enable = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (src0_ready !== 1'b1 || src1_ready !== 1'b0 || ser_rts !== 1'b0) begin
      failures++;
      $display("FAIL basic_fill: r0=%b r1=%b rts=%b required 1 0 0",
               src0_ready, src1_ready, ser_rts);
    end
    @(negedge clk);
    src0_valid = 1'b0;
    checks++;
    if (ser_rts !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_rts: rts=%b busy=%b required 1 1",
               ser_rts, busy);
    end
    repeat (5) @(negedge clk);
    ser_rtr = 1'b1;
    #1;
    checks++;
    if (ser_lft !== 16'h1234 || ser_rgt !== 16'hABCD) begin
      failures++;
      $display("FAIL basic_data: lft=%h rgt=%h required 1234 abcd",
               ser_lft, ser_rgt);
    end
    @(negedge clk);
    ser_rtr = 1'b0;
    #1;
    checks++;
    if (ser_lft !== 16'h0 || ser_rgt !== 16'h0 || underrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL basic_empty: lft=%h rgt=%h cnt=%0d required 0 0 0",
               ser_lft, ser_rgt, underrun_cnt);
    end
  endtask

  task automatic test_sck_period(input logic [7:0] div, input int per);
    int last;
    int edges;
    logic prev;
    do_reset();
    cfg_div = div;
    bring_up(1'b0, 16'h5555, 16'hAAAA);
    last = -1;
    edges = 0;
    prev = sck;
    for (int t = 0; t < 12 * per; t++) begin
      @(negedge clk);
      if (sck_transition) begin
        checks++;
        if (sck !== 1'b1 || prev !== 1'b0) begin
          failures++;
          $display("FAIL sck_edge: sck=%b prev=%b required 1 0", sck, prev);
        end
        if (last >= 0) begin
          checks++;
          if (t - last != per) begin
            failures++;
            $display("FAIL sck_period: got %0d required %0d", t - last, per);
          end
        end
        last = t;
        edges++;
      end else if (sck === 1'b1 && prev === 1'b0) begin
        checks++; failures++;
        $display("FAIL sck_no_pulse: sck rose with transition=0");
      end
      prev = sck;
    end
    checks++;
    if (edges < 10) begin
      failures++;
      $display("FAIL sck_count: got %0d rising edges required >=10", edges);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    bring_up(1'b0, 16'h0F0F, 16'hF0F0);
    ser_rtr = 1'b1;
    @(negedge clk);
    ser_rtr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ser_rtr = 1'b1;
      #1;
      checks++;
      if (ser_lft !== 16'h0 || ser_rgt !== 16'h0) begin
        failures++;
        $display("FAIL underrun_mute: lft=%h rgt=%h required 0 0",
                 ser_lft, ser_rgt);
      end
      @(negedge clk);
      ser_rtr = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (underrun_cnt !== 8'd3) begin
      failures++;
      $display("FAIL underrun_cnt3: got %0d required 3", underrun_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      ser_rtr = 1'b1;
      @(negedge clk);
      ser_rtr = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (underrun_cnt !== 8'd255) begin
      failures++;
      $display("FAIL underrun_sat: got %0d required 255", underrun_cnt);
    end
  endtask

  task automatic test_switch();
    do_reset();
    bring_up(1'b0, 16'h1111, 16'h2222);
    src1_lft = 16'h3333;
    src1_rgt = 16'h4444;
    src1_valid = 1'b1;
    @(negedge clk);
    cfg_src_sel = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (src0_ready !== 1'b0 || src1_ready !== 1'b0 || active_src !== 1'b0) begin
      failures++;
      $display("FAIL switch_hold: r0=%b r1=%b act=%b required 0 0 0",
               src0_ready, src1_ready, active_src);
    end
    ser_rtr = 1'b1;
    #1;
    checks++;
    if (ser_lft !== 16'h1111 || ser_rgt !== 16'h2222 || src1_ready !== 1'b0) begin
      failures++;
      $display("FAIL switch_old: lft=%h rgt=%h r1=%b required 1111 2222 0",
               ser_lft, ser_rgt, src1_ready);
    end
    @(negedge clk);
    ser_rtr = 1'b0;
    src0_valid = 1'b1;
    #1;
    checks++;
    if (active_src !== 1'b1 || src1_ready !== 1'b1 || src0_ready !== 1'b0) begin
      failures++;
      $display("FAIL switch_new: act=%b r1=%b r0=%b required 1 1 0",
               active_src, src1_ready, src0_ready);
    end
    @(negedge clk);
    src1_valid = 1'b0;
    ser_rtr = 1'b1;
    #1;
    checks++;
    if (ser_lft !== 16'h3333 || ser_rgt !== 16'h4444 || src0_ready !== 1'b0) begin
      failures++;
      $display("FAIL switch_data: lft=%h rgt=%h r0=%b required 3333 4444 0",
               ser_lft, ser_rgt, src0_ready);
    end
    @(negedge clk);
    ser_rtr = 1'b0;
    src0_valid = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    bring_up(1'b0, 16'h7777, 16'h8888);
    ser_rtr = 1'b1;
    @(negedge clk);
    ser_rtr = 1'b0;
    cfg_enable = 1'b0;
    @(negedge clk);
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold: busy=%b r0=%b r1=%b required 1 0 0",
                 busy, src0_ready, src1_ready);
      end
      @(negedge clk);
    end
    ser_rtr = 1'b1;
    @(negedge clk);
    ser_rtr = 1'b0;
    checks++;
    if (busy !== 1'b0 || sck !== 1'b0 || ser_rts !== 1'b0) begin
      failures++;
      $display("FAIL drain_idle: busy=%b sck=%b rts=%b required 0 0 0",
               busy, sck, ser_rts);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || src0_ready !== 1'b1 || ser_rts !== 1'b0) begin
      failures++;
      $display("FAIL restart_fill: busy=%b r0=%b rts=%b required 1 1 0",
               busy, src0_ready, ser_rts);
    end
    @(negedge clk);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    checks++;
    if (ser_rts !== 1'b1) begin
      failures++;
      $display("FAIL restart_rts: got %b required 1", ser_rts);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bring_up(1'b0, 16'h9999, 16'h6666);
    ser_rtr = 1'b1;
    @(negedge clk);
    ser_rtr = 1'b0;
    src0_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sck, sck_transition, ser_rts, src0_ready, src1_ready,
         active_src, busy} !== 7'b0 || {ser_lft, ser_rgt} !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: ctl=%b lft=%h required 0",
               {sck, sck_transition, ser_rts, src0_ready, src1_ready,
                active_src, busy}, ser_lft);
    end
    @(negedge clk);
    cfg_enable = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ser_rts !== 1'b0 || src0_ready !== 1'b0 ||
        underrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_idle: busy=%b rts=%b r0=%b cnt=%0d required 0",
               busy, ser_rts, src0_ready, underrun_cnt);
    end
    src0_valid = 1'b0;
  endtask

  // scoreboard: samples accepted from the active source come out in order,
  // one per frame; an empty frame is muted and counted
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] got;
    logic [31:0] exp;
    logic        m_active;
    int          exp_under;
    do_reset();
    cfg_div = 8'($urandom_range(0, 4));
    m_active = 1'($urandom_range(0, 1));
    cfg_src_sel = m_active;
    cfg_enable = 1'b1;
    exp_under = 0;
    @(negedge clk);
    for (int c = 0; c < 2000; c++) begin
      src0_valid = ($urandom_range(0, 9) < 7);
      src1_valid = ($urandom_range(0, 9) < 7);
      src0_lft = 16'($urandom);
      src0_rgt = 16'($urandom);
      src1_lft = 16'($urandom);
      src1_rgt = 16'($urandom);
      if ($urandom_range(0, 19) == 0) cfg_src_sel = ~cfg_src_sel;
      ser_rtr = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (active_src !== m_active) begin
        failures++;
        $display("FAIL rand_active: got %b required %b", active_src, m_active);
      end
      if (src0_ready || src1_ready) begin
        checks++;
        if ((m_active ? src0_ready : src1_ready) || q.size() != 0 ||
            ser_rtr || !(m_active ? src1_valid : src0_valid)) begin
          failures++;
          $display("FAIL rand_ready: r0=%b r1=%b held=%0d rtr=%b",
                   src0_ready, src1_ready, q.size(), ser_rtr);
        end else begin
          q.push_back(m_active ? {src1_lft, src1_rgt} : {src0_lft, src0_rgt});
        end
      end
      if (ser_rtr) begin
        got = {ser_lft, ser_rgt};
        if (q.size() != 0) begin
          exp = q.pop_front();
        end else begin
          exp = 32'd0;
          exp_under++;
        end
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rand_data: got %h required %h", got, exp);
        end
        m_active = cfg_src_sel;
      end
      @(negedge clk);
    end
    ser_rtr = 1'b0;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    checks++;
    if (underrun_cnt !== 8'((exp_under > 255) ? 255 : exp_under)) begin
      failures++;
      $display("FAIL rand_underrun: got %0d required %0d",
               underrun_cnt, (exp_under > 255) ? 255 : exp_under);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sck_period(8'd3, 8);
    test_sck_period(8'd0, 4);
    test_underrun();
    test_switch();
    test_drain();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
